// File: rtl/phase_shift_pkg.sv
// Shared definitions for the multi-channel DCM phase-shift controller.
//   ps_state_e  : per-channel FSM state encoding
//   ERR_OVF/TMO : bit positions inside each channel's 2-bit error field
//   PSEN_CYCLES : width of a DCM PSEN pulse in clk_i cycles
//   clamp_phase : saturate a requested phase to +/-lim
package phase_shift_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_IDLE      = 2'd1,
    ST_STEP      = 2'd2,
    ST_WAIT_DONE = 2'd3
  } ps_state_e;

  localparam int ERR_OVF     = 0;
  localparam int ERR_TMO     = 1;
  localparam int PSEN_CYCLES = 1;

  function automatic int clamp_phase(input int v, input int lim);
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

endpackage

// File: rtl/phase_step_unit.sv
// One DCM phase-shift channel: walks the DCM phase one PSEN step at a time
// from the actual phase towards a latched, saturated target.
// Optional feature: define PHASE_TIMEOUT_EN to abort a step whose PSDONE
// does not arrive within TMO cycles (sets err bit1).
//
// Ports
//   clk_i, rst_n_i        clock and synchronised active-low reset
//   default_i             DCM phase after its own reset / relock
//   value_i, load_i       requested phase and load strobe
//   value_o               actual DCM phase
//   done_o, busy_o        target reached pulse / stepping in progress
//   psen_o, psincdec_o    DCM phase-shift controls
//   psdone_i, ovf_i       DCM PSDONE and STATUS[0]
//   locked_i              DCM lock (already qualified)
//   clear_err_i, err_o    sticky errors {timeout, overflow}
//
// state        | meaning
// -------------+-----------------------------------------------------
// WAIT_LOCK    | DCM unlocked; actual follows default_i, no stepping
// IDLE         | compare actual with target, report done
// STEP         | one-cycle PSEN pulse, direction latched
// WAIT_DONE    | waiting for PSDONE (or timeout) to commit the step
module phase_step_unit
  import phase_shift_pkg::*;
#(
  parameter int PW   = 9,
  parameter int PMAX = 255,
  parameter int TMO  = 1024
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic [PW-1:0] default_i,
  input  logic [PW-1:0] value_i,
  input  logic          load_i,
  output logic [PW-1:0] value_o,
  output logic          done_o,
  output logic          busy_o,
  output logic          psen_o,
  output logic          psincdec_o,
  input  logic          psdone_i,
  input  logic          ovf_i,
  input  logic          locked_i,
  input  logic          clear_err_i,
  output logic [1:0]    err_o
);

  if (PMAX < 1 || PMAX >= (1 << (PW - 1))) begin : g_pmax_chk
    $error("PMAX must fit in a signed PW-bit value");
  end
  if (TMO < 2) begin : g_tmo_chk
    $error("TMO must be at least 2");
  end

  ps_state_e             state_q, state_d;
  logic signed [PW-1:0]  actual_q, actual_d;
  logic signed [PW-1:0]  tgt_q, tgt_d;
  logic                  tgt_vld_q, tgt_vld_d;
  logic                  dir_q, dir_d;
  logic                  pend_q, pend_d;
  logic [1:0]            err_q, err_d;

  logic signed [PW-1:0]  tgt;
  logic signed [PW-1:0]  load_val;
  logic                  step_up;
  logic                  tmo_hit;

  // Until the first lock the target is simply the DCM default phase.
  assign tgt      = tgt_vld_q ? tgt_q : $signed(default_i);
  assign load_val = PW'(clamp_phase(int'($signed(value_i)), PMAX));
  assign step_up  = (tgt > actual_q);

`ifdef PHASE_TIMEOUT_EN
  localparam int CW = (TMO > 2) ? $clog2(TMO) : 1;
  logic [CW-1:0] tmo_q, tmo_d;

  // Loaded in STEP so the terminal count lands on the TMO-th cycle after PSEN.
  always_comb begin
    tmo_d = tmo_q;
    if (state_q == ST_STEP) tmo_d = CW'(TMO - 2);
    else if (state_q == ST_WAIT_DONE && tmo_q != '0) tmo_d = tmo_q - CW'(1);
  end

  assign tmo_hit = (state_q == ST_WAIT_DONE) && (tmo_q == '0) && !psdone_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) tmo_q <= '0;
    else          tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    actual_d   = actual_q;
    tgt_d      = tgt_q;
    tgt_vld_d  = tgt_vld_q;
    dir_d      = dir_q;
    pend_d     = pend_q;
    err_d      = err_q;
    value_o    = actual_q;
    done_o     = 1'b0;
    busy_o     = 1'b0;
    psen_o     = 1'b0;
    psincdec_o = 1'b0;

    if (clear_err_i) err_d = '0;

    unique case (state_q)
      ST_WAIT_LOCK: begin
        value_o  = default_i;
        actual_d = default_i;
        if (!tgt_vld_q) tgt_d = default_i;
        if (locked_i) begin
          tgt_vld_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (actual_q != tgt) begin
          busy_o  = 1'b1;
          state_d = ST_STEP;
        end else if (pend_q) begin
          done_o = 1'b1;
          pend_d = 1'b0;
        end
      end
      ST_STEP: begin
        busy_o     = 1'b1;
        psen_o     = 1'b1;
        psincdec_o = step_up;
        dir_d      = step_up;
        state_d    = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        busy_o = 1'b1;
        if (psdone_i) begin
          pend_d  = 1'b1;
          state_d = ST_IDLE;
          if (ovf_i) begin
            // DCM refused the step: stop where it is.
            tgt_d          = actual_q;
            tgt_vld_d      = 1'b1;
            err_d[ERR_OVF] = 1'b1;
          end else begin
            actual_d = dir_q ? actual_q + PW'(1) : actual_q - PW'(1);
          end
        end else if (tmo_hit) begin
          tgt_d          = actual_q;
          tgt_vld_d      = 1'b1;
          err_d[ERR_TMO] = 1'b1;
          pend_d         = 1'b1;
          state_d        = ST_IDLE;
        end
      end
      default: state_d = ST_WAIT_LOCK;
    endcase

    if (load_i) begin
      tgt_d     = load_val;
      tgt_vld_d = 1'b1;
      pend_d    = 1'b1;
    end

    // Lock loss overrides everything; the target survives for the re-step.
    if (!locked_i) state_d = ST_WAIT_LOCK;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_WAIT_LOCK;
      actual_q  <= '0;
      tgt_q     <= '0;
      tgt_vld_q <= 1'b0;
      dir_q     <= 1'b0;
      pend_q    <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      actual_q  <= actual_d;
      tgt_q     <= tgt_d;
      tgt_vld_q <= tgt_vld_d;
      dir_q     <= dir_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/phase_shift_multi.sv
// NCH independent DCM phase-shift channels sharing one clock and one
// reset synchroniser. Optional macro PHASE_TIMEOUT_EN enables the per-channel
// PSDONE timeout (err bit1); without it err bit1 is always 0.
//
// Ports
//   clk_i, reset_n_i      clock (also DCM PSCLK), async active-low reset
//   default_i             DCM phase after its own reset
//   value_i, load_i       packed per-channel requested phase / load strobes
//   value_o               packed per-channel actual phase
//   done_o, busy_o        per-channel done pulse / busy
//   dcm_psen_o, dcm_psincdec_o, dcm_psdone_i, dcm_ovf_i, dcm_locked_i
//                         per-channel DCM phase-shift interface
//   clear_err_i, err_o    clear all sticky errors / {tmo,ovf} per channel
module phase_shift_multi
  import phase_shift_pkg::*;
#(
  parameter int NCH  = 2,
  parameter int PW   = 9,
  parameter int PMAX = 255,
  parameter int TMO  = 1024
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic [PW-1:0]     default_i,
  input  logic [NCH*PW-1:0] value_i,
  input  logic [NCH-1:0]    load_i,
  output logic [NCH*PW-1:0] value_o,
  output logic [NCH-1:0]    done_o,
  output logic [NCH-1:0]    busy_o,
  output logic [NCH-1:0]    dcm_psen_o,
  output logic [NCH-1:0]    dcm_psincdec_o,
  input  logic [NCH-1:0]    dcm_psdone_i,
  input  logic [NCH-1:0]    dcm_ovf_i,
  input  logic [NCH-1:0]    dcm_locked_i,
  input  logic              clear_err_i,
  output logic [2*NCH-1:0]  err_o
);

  if (NCH < 1 || NCH > 8) begin : g_nch_chk
    $error("NCH must be 1..8");
  end

  // Assertion is asynchronous through the flop clears; release takes two edges.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) rst_sync_q <= '0;
    else            rst_sync_q <= rst_sync_d;
  end

  assign rst_n = rst_sync_q[1];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    phase_step_unit #(
      .PW  (PW),
      .PMAX(PMAX),
      .TMO (TMO)
    ) u_step (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n),
      .default_i  (default_i),
      .value_i    (value_i[i*PW +: PW]),
      .load_i     (load_i[i]),
      .value_o    (value_o[i*PW +: PW]),
      .done_o     (done_o[i]),
      .busy_o     (busy_o[i]),
      .psen_o     (dcm_psen_o[i]),
      .psincdec_o (dcm_psincdec_o[i]),
      .psdone_i   (dcm_psdone_i[i]),
      .ovf_i      (dcm_ovf_i[i]),
      .locked_i   (dcm_locked_i[i]),
      .clear_err_i(clear_err_i),
      .err_o      (err_o[2*i +: 2])
    );
  end

endmodule

// File: tb/tb_phase_shift_multi.sv
module tb_phase_shift_multi;
  import phase_shift_pkg::*;

  localparam int NCH  = 2;
  localparam int PW   = 10;
  localparam int PMAX = 255;
  localparam int TMO  = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [PW-1:0]     default_in;
  logic [NCH*PW-1:0] value_in;
  logic [NCH-1:0]    load;
  logic [NCH*PW-1:0] value_o;
  logic [NCH-1:0]    done, busy, psen, psincdec, psdone, ovf, locked;
  logic              clear_err;
  logic [2*NCH-1:0]  err;

  int n_cmp = 0;
  int n_bad = 0;

  // DCM model / monitor state
  int cyc = 0;
  int viol = 0;
  int pen_cnt[NCH], inc_cnt[NCH], done_seen[NCH], pdone_n[NCH];
  int pd_cnt[NCH], pd_dly[NCH], ovf_at[NCH], last_psen[NCH], min_gap[NCH], psen_run[NCH];
  bit resp_en[NCH];
  bit prev_done[NCH];

  always #5 clk = ~clk;

  phase_shift_multi #(.NCH(NCH), .PW(PW), .PMAX(PMAX), .TMO(TMO)) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .default_i     (default_in),
    .value_i       (value_in),
    .load_i        (load),
    .value_o       (value_o),
    .done_o        (done),
    .busy_o        (busy),
    .dcm_psen_o    (psen),
    .dcm_psincdec_o(psincdec),
    .dcm_psdone_i  (psdone),
    .dcm_ovf_i     (ovf),
    .dcm_locked_i  (locked),
    .clear_err_i   (clear_err),
    .err_o         (err)
  );

  function automatic logic [PW-1:0] ph(input int v);
    return PW'(v);
  endfunction

  function automatic logic [PW-1:0] val(input int c);
    return value_o[c*PW +: PW];
  endfunction

  // DCM responder: answers each PSEN with PSDONE after pd_dly cycles,
  // optionally flagging overflow on the ovf_at-th PSDONE.
  initial begin
    psdone = '0;
    ovf    = '0;
    forever begin
      @(negedge clk);
      cyc++;
      for (int c = 0; c < NCH; c++) begin
        psdone[c] = 1'b0;
        ovf[c]    = 1'b0;
        if (pd_cnt[c] > 0) begin
          pd_cnt[c]--;
          if (pd_cnt[c] == 0) begin
            pdone_n[c]++;
            psdone[c] = 1'b1;
            ovf[c]    = (ovf_at[c] != 0 && pdone_n[c] == ovf_at[c]);
          end
        end
        if (psen[c] === 1'b1) begin
          psen_run[c]++;
          if (psen_run[c] > PSEN_CYCLES || pd_cnt[c] > 0) viol++;
          pen_cnt[c]++;
          if (psincdec[c] === 1'b1) inc_cnt[c]++;
          if (last_psen[c] >= 0 && cyc - last_psen[c] < min_gap[c]) min_gap[c] = cyc - last_psen[c];
          last_psen[c] = cyc;
          if (resp_en[c]) pd_cnt[c] = pd_dly[c];
        end else begin
          psen_run[c] = 0;
        end
        if (done[c] === 1'b1) begin
          done_seen[c]++;
          if (prev_done[c]) viol++;
        end
        prev_done[c] = (done[c] === 1'b1);
      end
    end
  end

  task automatic clr_mon();
    for (int c = 0; c < NCH; c++) begin
      pen_cnt[c] = 0; inc_cnt[c] = 0; done_seen[c] = 0; pdone_n[c] = 0;
      last_psen[c] = -1; min_gap[c] = 1000;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; locked = '1; load = '0; clear_err = 1'b0;
    default_in = '0; value_in = '0;
    for (int c = 0; c < NCH; c++) begin
      resp_en[c] = 1'b1; ovf_at[c] = 0; pd_cnt[c] = 0;
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    clr_mon();
  endtask

  task automatic load_ch(input int c, input int v);
    @(negedge clk);
    value_in[c*PW +: PW] = ph(v);
    load[c] = 1'b1;
    @(negedge clk);
    load[c] = 1'b0;
  endtask

  task automatic wait_done(input int c, input int budget);
    int n = 0;
    while (done_seen[c] == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (done_seen[c] == 0) begin
      n_bad++;
      $display("FAIL wait_done ch%0d: no done_o pulse within %0d cycles, required one", c, budget);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; locked = '1; load = '0; clear_err = 1'b0; value_in = '0;
    default_in = ph(7);
    for (int c = 0; c < NCH; c++) begin
      resp_en[c] = 1'b1; ovf_at[c] = 0; pd_cnt[c] = 0; pd_dly[c] = (c == 0) ? 1 : 3;
    end
    repeat (2) @(negedge clk);
    n_cmp++; if (value_o !== {ph(7), ph(7)}) begin n_bad++; $display("FAIL rst_value: got %h want %h", value_o, {ph(7), ph(7)}); end
    n_cmp++; if ({psen, psincdec, done, busy} !== 8'h00) begin n_bad++; $display("FAIL rst_ctrl: got %b want 00000000", {psen, psincdec, done, busy}); end
    n_cmp++; if (err !== 4'b0000) begin n_bad++; $display("FAIL rst_err: got %b want 0000", err); end
    default_in = '0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    clr_mon();
    n_cmp++; if (value_o !== '0 || busy !== 2'b00) begin n_bad++; $display("FAIL rst_locked_idle: value %h busy %b, want 0 and 00", value_o, busy); end
  endtask

  task automatic test_single();
    load_ch(0, 5);
    wait_done(0, 200);
    n_cmp++; if (pen_cnt[0] != 5 || inc_cnt[0] != 5) begin n_bad++; $display("FAIL single_psen: psen %0d inc %0d, want 5 and 5", pen_cnt[0], inc_cnt[0]); end
    n_cmp++; if (val(0) !== ph(5)) begin n_bad++; $display("FAIL single_value: got %h want %h", val(0), ph(5)); end
    n_cmp++; if (done_seen[0] != 1) begin n_bad++; $display("FAIL single_done_cnt: got %0d want 1", done_seen[0]); end
    n_cmp++; if (busy !== 2'b00 || val(1) !== ph(0)) begin n_bad++; $display("FAIL single_after: busy %b ch1 %h, want 00 and 000", busy, val(1)); end
  endtask

  task automatic test_concurrent();
    int n = 0;
    bit both = 0, early = 0;
    clr_mon();
    @(negedge clk);
    value_in = {ph(-300), ph(-3)};
    load = 2'b11;
    @(negedge clk);
    load = 2'b00;
    while ((done_seen[0] == 0 || done_seen[1] == 0) && n < 3000) begin
      @(negedge clk);
      n++;
      if (busy === 2'b11) both = 1;
      if (done[0] === 1'b1 && busy[1] === 1'b1) early = 1;
    end
    repeat (4) @(negedge clk);
    n_cmp++; if (done_seen[0] != 1 || done_seen[1] != 1) begin n_bad++; $display("FAIL conc_done: got %0d/%0d want 1/1", done_seen[0], done_seen[1]); end
    n_cmp++; if (val(0) !== ph(-3) || pen_cnt[0] != 8 || inc_cnt[0] != 0) begin n_bad++; $display("FAIL conc_ch0: value %h psen %0d inc %0d, want %h 8 0", val(0), pen_cnt[0], inc_cnt[0], ph(-3)); end
    n_cmp++; if (val(1) !== ph(-255) || pen_cnt[1] != 255 || inc_cnt[1] != 0) begin n_bad++; $display("FAIL conc_sat: value %h psen %0d inc %0d, want %h 255 0", val(1), pen_cnt[1], inc_cnt[1], ph(-255)); end
    n_cmp++; if (!both || !early) begin n_bad++; $display("FAIL conc_overlap: both_busy %0d ch0_done_while_ch1_busy %0d, want 1 1", both, early); end
  endtask

  task automatic test_back_to_back();
    clr_mon();
    @(negedge clk);
    value_in[0 +: PW] = ph(7); load[0] = 1'b1;
    @(negedge clk);
    value_in[0 +: PW] = ph(6);
    @(negedge clk);
    load[0] = 1'b0;
    wait_done(0, 300);
    n_cmp++; if (val(0) !== ph(6) || pen_cnt[0] != 9 || inc_cnt[0] != 9) begin n_bad++; $display("FAIL b2b_last_load: value %h psen %0d inc %0d, want %h 9 9", val(0), pen_cnt[0], inc_cnt[0], ph(6)); end
    n_cmp++; if (min_gap[0] != 3) begin n_bad++; $display("FAIL b2b_step_period: got %0d want 3", min_gap[0]); end
    n_cmp++; if (done_seen[0] != 1) begin n_bad++; $display("FAIL b2b_done_cnt: got %0d want 1", done_seen[0]); end
    clr_mon();
    load_ch(0, 6);
    repeat (5) @(negedge clk);
    n_cmp++; if (done_seen[0] != 1 || pen_cnt[0] != 0 || busy[0] !== 1'b0) begin n_bad++; $display("FAIL equal_load: done %0d psen %0d busy %b, want 1 0 0", done_seen[0], pen_cnt[0], busy[0]); end
  endtask

  task automatic test_ovf();
    int n = 0;
    do_reset();
    ovf_at[0] = 3;
    load_ch(0, 10);
    wait_done(0, 200);
    n_cmp++; if (val(0) !== ph(2) || pen_cnt[0] != 3) begin n_bad++; $display("FAIL ovf_stop: value %h psen %0d, want %h 3", val(0), pen_cnt[0], ph(2)); end
    n_cmp++; if (err !== 4'b0001 || done_seen[0] != 1 || busy[0] !== 1'b0) begin n_bad++; $display("FAIL ovf_flags: err %b done %0d busy %b, want 0001 1 0", err, done_seen[0], busy[0]); end
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    n_cmp++; if (err !== 4'b0000) begin n_bad++; $display("FAIL clear_err: got %b want 0000", err); end
    // clear coinciding with a new overflow: the set must win
    clr_mon();
    ovf_at[0] = 1;
    load_ch(0, 5);
    while (psen[0] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    n_cmp++; if (err[0] !== 1'b1 || val(0) !== ph(2)) begin n_bad++; $display("FAIL set_wins: err0 %b value %h, want 1 %h", err[0], val(0), ph(2)); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_lock_loss();
    int n = 0;
    do_reset();
    load_ch(0, 8);
    while (val(0) !== ph(4) && n < 200) begin @(negedge clk); n++; end
    locked[0] = 1'b0;
    n_cmp++; if (val(0) !== ph(4)) begin n_bad++; $display("FAIL lock_reach4: got %h want %h", val(0), ph(4)); end
    @(negedge clk);
    n_cmp++; if (val(0) !== ph(0) || busy[0] !== 1'b0 || psen[0] !== 1'b0) begin n_bad++; $display("FAIL lock_drop: value %h busy %b psen %b, want 000 0 0", val(0), busy[0], psen[0]); end
    repeat (3) @(negedge clk);
    clr_mon();
    locked[0] = 1'b1;
    wait_done(0, 300);
    n_cmp++; if (pen_cnt[0] != 8 || inc_cnt[0] != 8 || val(0) !== ph(8) || done_seen[0] != 1) begin n_bad++; $display("FAIL relock: psen %0d inc %0d value %h done %0d, want 8 8 %h 1", pen_cnt[0], inc_cnt[0], val(0), done_seen[0], ph(8)); end
  endtask

  task automatic test_timeout();
    int n = 0;
    do_reset();
    resp_en[0] = 1'b0;
    load_ch(0, 1);
`ifdef PHASE_TIMEOUT_EN
    while (psen[0] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    n_cmp++; if (psen[0] !== 1'b1) begin n_bad++; $display("FAIL tmo_psen: got %b want 1", psen[0]); end
    repeat (TMO - 1) @(negedge clk);
    n_cmp++; if (err[1] !== 1'b0 || busy[0] !== 1'b1) begin n_bad++; $display("FAIL tmo_early: err1 %b busy %b, want 0 1", err[1], busy[0]); end
    @(negedge clk);
    n_cmp++; if (err[1] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b1 || val(0) !== ph(0)) begin n_bad++; $display("FAIL tmo_hit: err1 %b busy %b done %b value %h, want 1 0 1 000", err[1], busy[0], done[0], val(0)); end
    repeat (4) @(negedge clk);
    n_cmp++; if (pen_cnt[0] != 1) begin n_bad++; $display("FAIL tmo_no_restep: psen %0d want 1", pen_cnt[0]); end
`else
    repeat (40) @(negedge clk);
    n++;
    n_cmp++; if (err[1] !== 1'b0 || busy[0] !== 1'b1 || pen_cnt[0] != n) begin n_bad++; $display("FAIL no_tmo_wait: err1 %b busy %b psen %0d, want 0 1 1", err[1], busy[0], pen_cnt[0]); end
`endif
  endtask

  task automatic test_async_reset();
    do_reset();
    resp_en[0] = 1'b0;
    ovf_at[1] = 2;
    @(negedge clk);
    value_in = {ph(2), ph(3)};
    load = 2'b11;
    @(negedge clk);
    load = 2'b00;
    wait_done(1, 200);
    n_cmp++; if (busy[0] !== 1'b1 || err !== 4'b0100 || val(1) !== ph(1)) begin n_bad++; $display("FAIL pre_async: busy0 %b err %b ch1 %h, want 1 0100 %h", busy[0], err, val(1), ph(1)); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (value_o !== '0 || err !== 4'b0000) begin n_bad++; $display("FAIL async_rst_data: value %h err %b, want 0 0000", value_o, err); end
    n_cmp++; if ({psen, psincdec, done, busy} !== 8'h00) begin n_bad++; $display("FAIL async_rst_ctrl: got %b want 00000000", {psen, psincdec, done, busy}); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_protocol();
    n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL protocol: %0d psen/done shape violations, want 0", viol); end
  endtask

  initial begin
    clr_mon();
    test_reset();
    test_single();
    test_concurrent();
    test_back_to_back();
    test_ovf();
    test_lock_loss();
    test_timeout();
    test_async_reset();
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
